alu_result_collector: RTL

Parametrised, sequential successor to the ALU's 8:1 result selector. It accepts an operation select through a valid/ready command handshake and issues a one-cycle start pulse to the selected functional unit. It then waits for that unit's completion, captures the unit's result slice and holds it behind a valid/ready result handshake. Multi-cycle units (modulo, divide) and single-cycle units (and, or, add, and so on) share one collector. A watchdog converts a unit that never completes into an error response.

---
 rtl/alu_result_collector.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_result_collector.sv
// -----------------------------------------------------------------------------
// alu_result_collector
//
// Sequential successor to the ALU's 8:1 result selector. The collector accepts
// an operation select over a valid/ready command handshake and fires a
// one-cycle start pulse at the selected functional unit. It then waits for
// that unit's completion, captures its result slice and presents it behind a
// valid/ready result handshake. Single-cycle units (done tied high) and
// multi-cycle units (modulo, divide) share the same path. An optional watchdog
// turns a unit that never completes into an error response with a zero result.
//
// Parameters
//   WIDTH    result width of each source
//   SEL_W    select width; NUM_SRC = 2**SEL_W sources
//   TIMEOUT  WAIT cycles before an error response; 0 disables the watchdog
//
// Ports
//   clk        in   1              rising-edge clock
//   rst_n      in   1              asynchronous active-low reset
//   cmd_valid  in   1              command offered
//   cmd_ready  out  1              command can be accepted (IDLE only)
//   cmd_sel    in   SEL_W          source index of the command
//   src_start  out  NUM_SRC        one-hot, one-cycle start pulse
//   src_done   in   NUM_SRC        per-source completion
//   src_data   in   NUM_SRC*WIDTH  flattened source results, source i at i*WIDTH
//   res_valid  out  1              captured result is being held
//   res_ready  in   1              consumer accepts the held result
//   result     out  WIDTH          captured result (0 on timeout)
//   res_err    out  1              result was produced by the watchdog
//   busy       out  1              collector is not IDLE
//
// Every output is either a flop or a decode of the state register, so there
// is no combinational path from cmd_* or src_* to any output.
// -----------------------------------------------------------------------------
module alu_result_collector #(
    parameter int WIDTH   = 32,
    parameter int SEL_W   = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [SEL_W-1:0]              cmd_sel,
    output logic [(2**SEL_W)-1:0]         src_start,
    input  logic [(2**SEL_W)-1:0]         src_done,
    input  logic [(2**SEL_W)*WIDTH-1:0]   src_data,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [WIDTH-1:0]              result,
    output logic                          res_err,
    output logic                          busy
);

    localparam int NUM_SRC = 2**SEL_W;

    // The timer only has to reach TIMEOUT-1: the WAIT cycle numbered TIMEOUT
    // is the one where timer == TIMEOUT-1, and WAIT is left on that cycle.
    localparam int TIMER_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TIMEOUT_LAST = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;

    localparam logic [TIMER_W-1:0] TIMER_ZERO = TIMER_W'(0);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_LAST);
    localparam bit                 WDOG_EN    = (TIMEOUT != 0);

    // Legacy-compatible 2-bit state encoding.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // One-hot decode of a source index.
    function automatic logic [NUM_SRC-1:0] onehot_sel(input logic [SEL_W-1:0] idx);
        logic [NUM_SRC-1:0] vec;
        vec      = {NUM_SRC{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Extract the WIDTH-bit result slice of one source from the flat bus.
    function automatic logic [WIDTH-1:0] pick_slice(
        input logic [NUM_SRC*WIDTH-1:0] bus,
        input logic [SEL_W-1:0]         idx
    );
        return bus[int'(idx) * WIDTH +: WIDTH];
    endfunction

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    logic [1:0]         state_r;
    logic [SEL_W-1:0]   sel_r;
    logic [TIMER_W-1:0] timer_r;
    logic [WIDTH-1:0]   result_r;
    logic               res_err_r;
    logic [NUM_SRC-1:0] src_start_r;

    // Next-state values
    logic [1:0]         state_s;
    logic [SEL_W-1:0]   sel_s;
    logic [TIMER_W-1:0] timer_s;
    logic [WIDTH-1:0]   result_s;
    logic               res_err_s;
    logic [NUM_SRC-1:0] src_start_s;

    // Decoded WAIT-phase events
    logic               done_hit_s;
    logic               timeout_hit_s;
    logic [WIDTH-1:0]   sel_data_s;
    logic [TIMER_W-1:0] timer_inc_s;

    // Completion, watchdog and data-select decode for the latched source.
    always_comb begin
        done_hit_s    = src_done[sel_r];
        timeout_hit_s = WDOG_EN && (timer_r == TIMER_LAST);
        sel_data_s    = pick_slice(src_data, sel_r);
        if (WDOG_EN) begin
            timer_inc_s = timer_r + TIMER_ONE;
        end else begin
            // Without a watchdog the timer has no purpose; keep it parked so
            // it can never wrap during an arbitrarily long wait.
            timer_inc_s = timer_r;
        end
    end

    // Next-state and next-datapath logic of the IDLE/WAIT/HOLD controller.
    always_comb begin
        state_s     = state_r;
        sel_s       = sel_r;
        timer_s     = timer_r;
        result_s    = result_r;
        res_err_s   = res_err_r;
        src_start_s = {NUM_SRC{1'b0}};

        case (state_r)
            ST_IDLE: begin
                // cmd_ready is high throughout IDLE, so cmd_valid alone
                // completes the command handshake here.
                if (cmd_valid) begin
                    state_s     = ST_WAIT;
                    sel_s       = cmd_sel;
                    timer_s     = TIMER_ZERO;
                    src_start_s = onehot_sel(cmd_sel);
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_WAIT: begin
                // Completion is checked first so that a unit finishing on
                // the very last allowed cycle still returns its data.
                if (done_hit_s) begin
                    result_s  = sel_data_s;
                    res_err_s = 1'b0;
                    state_s   = ST_HOLD;
                end else if (timeout_hit_s) begin
                    result_s  = {WIDTH{1'b0}};
                    res_err_s = 1'b1;
                    state_s   = ST_HOLD;
                end else begin
                    timer_s = timer_inc_s;
                    state_s = ST_WAIT;
                end
            end

            ST_HOLD: begin
                if (res_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end

            default: begin
                // Unreachable encoding: fall back to a clean IDLE.
                state_s   = ST_IDLE;
                result_s  = {WIDTH{1'b0}};
                res_err_s = 1'b0;
            end
        endcase
    end

    // Controller and datapath flops with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            sel_r       <= {SEL_W{1'b0}};
            timer_r     <= TIMER_ZERO;
            result_r    <= {WIDTH{1'b0}};
            res_err_r   <= 1'b0;
            src_start_r <= {NUM_SRC{1'b0}};
        end else begin
            state_r     <= state_s;
            sel_r       <= sel_s;
            timer_r     <= timer_s;
            result_r    <= result_s;
            res_err_r   <= res_err_s;
            src_start_r <= src_start_s;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: flops or pure state decodes
    // -------------------------------------------------------------------------
    assign cmd_ready = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
    assign res_valid = (state_r == ST_HOLD);
    assign src_start = src_start_r;
    assign result    = result_r;
    assign res_err   = res_err_r;

endmodule
